// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default constants for the fetch redirect
//               sequencer and its bus watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    REDIRECT = 2'd2,
    SETTLE   = 2'd3
  } fetch_ctl_state_t;

  // Which kind of redirect is latched
  typedef enum logic [1:0] {
    RC_NONE = 2'd0,
    RC_TRAP = 2'd1,
    RC_BJ   = 2'd2
  } redirect_cause_t;

  localparam int unsigned c_SETTLE_CYCLES_DEF = 1;
  localparam int unsigned c_BUSY_TIMEOUT_DEF  = 1024;

endpackage
`default_nettype wire

// File: rtl/fetch_wdog.sv
`default_nettype none
// ============================================================================
// Module      : fetch_wdog
// Description : Instcache bus-hang watchdog. Counts consecutive ic_busy
//               cycles (saturating) and raises a sticky hang_err once the
//               run length reaches BUSY_TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_wdog
  import fetch_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = c_BUSY_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ic_busy,
  output logic hang_err
);

  localparam int unsigned           c_cnt_w = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0]    c_limit = c_cnt_w'(BUSY_TIMEOUT);
  localparam logic [c_cnt_w-1:0]    c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_hang;

  // Next busy-run length: reset on an idle bus, saturate at the limit
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!ic_busy) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != c_limit) begin
      w_cnt_nxt = r_cnt + c_one;
    end
  end

  // Counter register and sticky hang flag (set the cycle the limit is reached)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_hang <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == c_limit) begin
        r_hang <= 1'b1;
      end
    end
  end

  assign hang_err = r_hang;

endmodule
`default_nettype wire

// File: rtl/fetch_ctl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctl
// Description : Front-end redirect and stall sequencer. Prioritises trap over
//               branch/jump redirects, holds them while instcache has a bus
//               transaction in flight, issues one redirect pulse and then
//               flushes stage_if_id for a settle window.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctl
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned SETTLE_CYCLES = c_SETTLE_CYCLES_DEF,
  parameter int unsigned BUSY_TIMEOUT  = c_BUSY_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            bj_req,
  input  logic [XLEN-1:0] bj_target,
  input  logic            back_stall,
  input  logic            ic_busy,
  output logic            stall,
  output logic            clear,
  output logic            trap_en,
  output logic [XLEN-1:0] trap_pc,
  output logic            bj_en,
  output logic [XLEN-1:0] bj_pc,
  output logic            redirect_pending,
  output logic            hang_err
);

  // Targets are halfword aligned at most: bit 0 is dropped, bit 1 kept
  localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-1){1'b1}}, 1'b0};
  // Settle counter reloads to SETTLE_CYCLES-1 so SETTLE lasts SETTLE_CYCLES
  localparam logic [1:0]      c_settle_load = 2'(SETTLE_CYCLES - 1);

  fetch_ctl_state_t r_state, w_state_nxt;
  redirect_cause_t  r_cause, w_cause_nxt;
  logic [XLEN-1:0]  r_target, w_target_nxt;
  logic [1:0]       r_settle_cnt, w_settle_nxt;

  logic             w_trap_en_nxt, w_bj_en_nxt, w_clear_nxt, w_pending_nxt;
  logic [XLEN-1:0]  w_trap_pc_nxt, w_bj_pc_nxt;

  logic             r_trap_en, r_bj_en, r_clear, r_pending;
  logic [XLEN-1:0]  r_trap_pc, r_bj_pc;

  // State, latched redirect and settle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cause      <= RC_NONE;
      r_target     <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cause      <= w_cause_nxt;
      r_target     <= w_target_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  // Next-state logic: accept/overwrite requests and sequence the flush
  always_comb begin
    w_state_nxt  = r_state;
    w_cause_nxt  = r_cause;
    w_target_nxt = r_target;
    w_settle_nxt = r_settle_cnt;
    case (r_state)
      IDLE: begin
        if (trap_req) begin
          w_cause_nxt  = RC_TRAP;
          w_target_nxt = trap_target & c_align_mask;
        end else if (bj_req) begin
          w_cause_nxt  = RC_BJ;
          w_target_nxt = bj_target & c_align_mask;
        end
        if (trap_req || bj_req) begin
          w_state_nxt = ic_busy ? WAIT_BUS : REDIRECT;
        end
      end
      WAIT_BUS: begin
        // A trap supersedes whatever is pending; late branches are dropped
        if (trap_req) begin
          w_cause_nxt  = RC_TRAP;
          w_target_nxt = trap_target & c_align_mask;
        end
        if (!ic_busy) begin
          w_state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        w_state_nxt  = SETTLE;
        w_settle_nxt = c_settle_load;
      end
      SETTLE: begin
        if (r_settle_cnt == 2'd0) begin
          w_state_nxt = IDLE;
          w_cause_nxt = RC_NONE;
        end else begin
          w_settle_nxt = r_settle_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cause_nxt = RC_NONE;
      end
    endcase
  end

  // Output logic: values the output flops take for the upcoming state
  always_comb begin
    w_trap_en_nxt = (w_state_nxt == REDIRECT) && (w_cause_nxt == RC_TRAP);
    w_bj_en_nxt   = (w_state_nxt == REDIRECT) && (w_cause_nxt == RC_BJ);
    w_clear_nxt   = (w_state_nxt == REDIRECT) || (w_state_nxt == SETTLE);
    w_pending_nxt = (w_state_nxt == WAIT_BUS);
    w_trap_pc_nxt = w_trap_en_nxt ? w_target_nxt : r_trap_pc;
    w_bj_pc_nxt   = w_bj_en_nxt   ? w_target_nxt : r_bj_pc;
  end

  // Registered outputs toward pc_ctl and stage_if_id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap_en <= 1'b0;
      r_bj_en   <= 1'b0;
      r_clear   <= 1'b0;
      r_pending <= 1'b0;
      r_trap_pc <= '0;
      r_bj_pc   <= '0;
    end else begin
      r_trap_en <= w_trap_en_nxt;
      r_bj_en   <= w_bj_en_nxt;
      r_clear   <= w_clear_nxt;
      r_pending <= w_pending_nxt;
      r_trap_pc <= w_trap_pc_nxt;
      r_bj_pc   <= w_bj_pc_nxt;
    end
  end

  fetch_wdog #(
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .ic_busy  (ic_busy),
    .hang_err (hang_err)
  );

  // Stall must react to the hazard in the same cycle, so it stays combinational
  assign stall            = back_stall | (r_state != IDLE);
  assign clear            = r_clear;
  assign trap_en          = r_trap_en;
  assign trap_pc          = r_trap_pc;
  assign bj_en            = r_bj_en;
  assign bj_pc            = r_bj_pc;
  assign redirect_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctl
// Description : Self-checking bench for fetch_ctl: directed scenarios plus
//               random traffic compared against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctl;

  localparam int XLEN    = 64;
  localparam int SETTLE  = 1;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            trap_req = 1'b0;
  logic [XLEN-1:0] trap_target = '0;
  logic            bj_req = 1'b0;
  logic [XLEN-1:0] bj_target = '0;
  logic            back_stall = 1'b0;
  logic            ic_busy = 1'b0;
  logic            stall, clear, trap_en, bj_en, redirect_pending, hang_err;
  logic [XLEN-1:0] trap_pc, bj_pc;

  always #5 clk = ~clk;

  fetch_ctl #(
    .XLEN          (XLEN),
    .SETTLE_CYCLES (SETTLE),
    .BUSY_TIMEOUT  (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trap_req         (trap_req),
    .trap_target      (trap_target),
    .bj_req           (bj_req),
    .bj_target        (bj_target),
    .back_stall       (back_stall),
    .ic_busy          (ic_busy),
    .stall            (stall),
    .clear            (clear),
    .trap_en          (trap_en),
    .trap_pc          (trap_pc),
    .bj_en            (bj_en),
    .bj_pc            (bj_pc),
    .redirect_pending (redirect_pending),
    .hang_err         (hang_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a latched redirect, a remaining-flush-cycles count and
  // a busy run length; expected outputs derive from these.
  bit          m_pending;
  bit          m_is_trap;
  logic [63:0] m_tgt;
  int          m_clear_left;
  bit          m_trap_en, m_bj_en;
  logic [63:0] m_trap_pc, m_bj_pc;
  int          m_busy_run;
  bit          m_hang;

  function void model_reset();
    m_pending    = 0;
    m_is_trap    = 0;
    m_tgt        = '0;
    m_clear_left = 0;
    m_trap_en    = 0;
    m_bj_en      = 0;
    m_trap_pc    = '0;
    m_bj_pc      = '0;
    m_busy_run   = 0;
    m_hang       = 0;
  endfunction

  function void model_edge();
    m_trap_en = 0;
    m_bj_en   = 0;
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else begin
      if (trap_req) begin
        m_pending = 1;
        m_is_trap = 1;
        m_tgt     = trap_target & ~64'h1;
      end else if (bj_req && !m_pending) begin
        m_pending = 1;
        m_is_trap = 0;
        m_tgt     = bj_target & ~64'h1;
      end
      if (m_pending && !ic_busy) begin
        if (m_is_trap) begin
          m_trap_en = 1;
          m_trap_pc = m_tgt;
        end else begin
          m_bj_en = 1;
          m_bj_pc = m_tgt;
        end
        m_pending    = 0;
        m_clear_left = 1 + SETTLE;
      end
    end
    if (ic_busy) begin
      if (m_busy_run < TIMEOUT) m_busy_run++;
    end else begin
      m_busy_run = 0;
    end
    if (m_busy_run >= TIMEOUT) m_hang = 1;
  endfunction

  task automatic check_all();
    chk("trap_en",  64'(trap_en),          64'(m_trap_en));
    chk("bj_en",    64'(bj_en),            64'(m_bj_en));
    chk("clear",    64'(clear),            64'(m_clear_left > 0));
    chk("pending",  64'(redirect_pending), 64'(m_pending));
    chk("stall",    64'(stall),            64'(back_stall | m_pending | (m_clear_left > 0)));
    chk("trap_pc",  trap_pc,               m_trap_pc);
    chk("bj_pc",    bj_pc,                 m_bj_pc);
    chk("hang_err", 64'(hang_err),         64'(m_hang));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Called at a falling edge; checks the asynchronous clear straight away
  task automatic reset_dut();
    back_stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_trap_en", 64'(trap_en),          64'd0);
    chk("rst_bj_en",   64'(bj_en),            64'd0);
    chk("rst_clear",   64'(clear),            64'd0);
    chk("rst_pending", 64'(redirect_pending), 64'd0);
    chk("rst_stall",   64'(stall),            64'd0);
    chk("rst_trap_pc", trap_pc,               64'd0);
    chk("rst_bj_pc",   bj_pc,                 64'd0);
    chk("rst_hang",    64'(hang_err),         64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge clk);
    reset_dut();

    // Plain branch redirect with an idle bus
    bj_req = 1'b1; bj_target = 64'h8000_0102; ic_busy = 1'b0;
    step();
    chk("tp1_bj_en", 64'(bj_en), 64'd1);
    chk("tp1_bj_pc", bj_pc, 64'h8000_0102);
    chk("tp1_clear", 64'(clear), 64'd1);
    bj_req = 1'b0;
    step();
    chk("tp1_bj_en_off", 64'(bj_en), 64'd0);
    chk("tp1_settle_clear", 64'(clear), 64'd1);
    step();
    chk("tp1_clear_off", 64'(clear), 64'd0);
    chk("tp1_stall_off", 64'(stall), 64'd0);

    // Simultaneous requests: trap wins
    trap_req = 1'b1; trap_target = 64'h1000; bj_req = 1'b1; bj_target = 64'h2000;
    step();
    chk("tp2_trap_en", 64'(trap_en), 64'd1);
    chk("tp2_trap_pc", trap_pc, 64'h1000);
    chk("tp2_bj_en", 64'(bj_en), 64'd0);
    trap_req = 1'b0; bj_req = 1'b0;
    step();
    step();

    // Bit 0 of a target is dropped, bit 1 kept
    bj_req = 1'b1; bj_target = 64'h8000_0003;
    step();
    chk("tp4_bj_pc", bj_pc, 64'h8000_0002);
    bj_req = 1'b0;
    step();
    step();

    // Pending branch overwritten by a trap while the bus is busy
    ic_busy = 1'b1; bj_req = 1'b1; bj_target = 64'h3000;
    step();
    bj_req = 1'b0;
    step();
    trap_req = 1'b1; trap_target = 64'h1000;
    step();
    chk("tp3_pending", 64'(redirect_pending), 64'd1);
    chk("tp3_stall", 64'(stall), 64'd1);
    trap_req = 1'b0;
    repeat (3) step();
    ic_busy = 1'b0;
    step();
    chk("tp3_trap_en", 64'(trap_en), 64'd1);
    chk("tp3_trap_pc", trap_pc, 64'h1000);
    chk("tp3_bj_en", 64'(bj_en), 64'd0);
    repeat (3) step();

    // Watchdog threshold and stickiness
    reset_dut();
    ic_busy = 1'b1;
    repeat (TIMEOUT - 1) step();
    chk("tp5_hang_pre", 64'(hang_err), 64'd0);
    step();
    chk("tp5_hang_set", 64'(hang_err), 64'd1);
    ic_busy = 1'b0;
    repeat (3) step();
    chk("tp5_hang_sticky", 64'(hang_err), 64'd1);
    reset_dut();

    // Reset while a redirect waits for the bus
    ic_busy = 1'b1; bj_req = 1'b1; bj_target = 64'h4444;
    step();
    bj_req = 1'b0;
    step();
    chk("tp6_pending", 64'(redirect_pending), 64'd1);
    reset_dut();
    ic_busy = 1'b0;
    repeat (4) begin
      step();
      chk("tp6_no_bj_en", 64'(bj_en), 64'd0);
    end

    // Random traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      trap_req    = ($urandom_range(0, 15) == 0);
      bj_req      = ($urandom_range(0, 5) == 0);
      trap_target = {$urandom, $urandom};
      bj_target   = {$urandom, $urandom};
      ic_busy     = ($urandom_range(0, 1) == 1);
      back_stall  = ($urandom_range(0, 3) == 0);
      step();
    end
    trap_req = 1'b0; bj_req = 1'b0; ic_busy = 1'b0; back_stall = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
